// File: rtl/gmii_pkg.sv
// gmii_pkg: shared state encoding, header offsets and constants for the GMII video receiver.
`default_nettype none

package gmii_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PRE     = 3'd1,
      S_HDR     = 3'd2,
      S_RESOL   = 3'd3,
      S_PAYLOAD = 3'd4,
      S_FCS     = 3'd5,
      S_DROP    = 3'd6
   } state_t;

   localparam logic [10:0] ETH_TYPE_OFF   = 11'd12;
   localparam logic [10:0] IP_PROT_OFF    = 11'd23;
   localparam logic [10:0] UDP_DPORT_OFF  = 11'd36;
   localparam logic [10:0] HDR_LAST_OFF   = 11'd41;
   localparam logic [10:0] RESOL_OFF      = 11'd42;
   localparam logic [10:0] RESOL_LAST_OFF = 11'd43;
   localparam logic [10:0] PAY_OFF        = 11'd44;

   localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
   localparam logic [7:0]  IP_PROT_UDP   = 8'h11;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

   // Data enters LSB first into an MSB-first register, so the register is the
   // bit-reverse of the usual reflected CRC and the good residue is 0xC704DD7B.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
         else                 c = {c[30:0], 1'b0};
      end
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/crc32_d8.sv
// crc32_d8: byte-wide Ethernet CRC-32 with synchronous seed and enable.
`default_nettype none

module crc32_d8
   import gmii_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   logic [31:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (init)    crc_d = CRC_INIT;
      else if (en) crc_d = crc32_byte(crc_q, data);
   end

   always_ff @(posedge clk) begin
      if (rst) crc_q <= CRC_INIT;
      else     crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/gmii_rx.sv
// gmii_rx: GMII receiver that filters UDP video frames and emits YCbCr pixel pairs.
`default_nettype none

module gmii_rx
   import gmii_pkg::*;
#(
   parameter logic [47:0] MY_MAC   = 48'h002345678902,
   parameter logic [15:0] UDP_PORT = 16'h3039,
   parameter logic [10:0] PAY_LEN  = 11'd1280
) (
   input  logic        rx_clk,
   input  logic        sys_rst,
   input  logic        rx_dv,
   input  logic        rx_er,
   input  logic [7:0]  rxd,
   input  logic        fifo_full,
   output logic        pix_wr,
   output logic [15:0] pix_data,
   output logic [9:0]  pix_x,
   output logic [10:0] pix_y,
   output logic        frame_ok,
   output logic        frame_err,
   output logic        hdr_drop
);

   localparam logic [10:0] PAY_LAST_OFF = PAY_OFF + PAY_LEN - 11'd1;
   localparam logic [10:0] FCS_DONE_OFF = PAY_OFF + PAY_LEN + 11'd4;

   state_t      state_q, state_d;
   logic [10:0] off_q, off_d;
   logic        err_pend_q, err_pend_d;
   logic        overflow_q, overflow_d;
   logic [7:0]  even_q, even_d;
   logic [2:0]  resol_hi_q, resol_hi_d;
   logic        pix_wr_q, pix_wr_d;
   logic [15:0] pix_data_q, pix_data_d;
   logic [9:0]  pix_x_q, pix_x_d;
   logic [10:0] pix_y_q, pix_y_d;
   logic        frame_ok_q, frame_ok_d;
   logic        frame_err_q, frame_err_d;
   logic        hdr_drop_q, hdr_drop_d;

   logic        crc_init, crc_en;
   logic [31:0] crc;
   logic        in_frame, hdr_accepted, byte_ok, ovf_now, fcs_done, hdr_bad;
   logic [7:0]  mac_byte;

   crc32_d8 u_crc (
      .clk  (rx_clk),
      .rst  (sys_rst),
      .init (crc_init),
      .en   (crc_en),
      .data (rxd),
      .crc  (crc)
   );

   assign in_frame     = state_q inside {S_HDR, S_RESOL, S_PAYLOAD, S_FCS};
   assign hdr_accepted = state_q inside {S_RESOL, S_PAYLOAD, S_FCS};
   assign byte_ok      = rx_dv && !rx_er;
   assign ovf_now      = overflow_q || (pix_wr_q && fifo_full);
   assign fcs_done     = (state_q == S_FCS) && (off_q == FCS_DONE_OFF);

   // Offset 0 carries the most significant MAC byte.
   always_comb begin
      mac_byte = 8'(MY_MAC >> (6'd40 - {off_q[2:0], 3'b000}));
      hdr_bad  = 1'b0;
      if (state_q == S_HDR) begin
         if (off_q < 11'd6)                              hdr_bad = (rxd != mac_byte);
         else if (off_q == ETH_TYPE_OFF)                 hdr_bad = (rxd != ETH_TYPE_IP[15:8]);
         else if (off_q == ETH_TYPE_OFF + 11'd1)         hdr_bad = (rxd != ETH_TYPE_IP[7:0]);
         else if (off_q == IP_PROT_OFF)                  hdr_bad = (rxd != IP_PROT_UDP);
         else if (off_q == UDP_DPORT_OFF)                hdr_bad = (rxd != UDP_PORT[15:8]);
         else if (off_q == UDP_DPORT_OFF + 11'd1)        hdr_bad = (rxd != UDP_PORT[7:0]);
      end
   end

   always_ff @(posedge rx_clk) begin
      if (sys_rst) begin
         state_q     <= S_IDLE;
         off_q       <= '0;
         err_pend_q  <= 1'b0;
         overflow_q  <= 1'b0;
         even_q      <= '0;
         resol_hi_q  <= '0;
         pix_wr_q    <= 1'b0;
         pix_data_q  <= '0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         hdr_drop_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         err_pend_q  <= err_pend_d;
         overflow_q  <= overflow_d;
         even_q      <= even_d;
         resol_hi_q  <= resol_hi_d;
         pix_wr_q    <= pix_wr_d;
         pix_data_q  <= pix_data_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         hdr_drop_q  <= hdr_drop_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      off_d      = off_q;
      err_pend_d = err_pend_q;
      overflow_d = ovf_now;
      crc_init   = 1'b0;
      crc_en     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_dv) state_d = (rxd == PREAMBLE_BYTE) ? S_PRE : S_DROP;
         end
         S_PRE: begin
            if (!rx_dv)                     state_d = S_IDLE;
            else if (rx_er)                 state_d = S_DROP;
            else if (rxd == SFD_BYTE) begin
               state_d    = S_HDR;
               off_d      = '0;
               crc_init   = 1'b1;
               overflow_d = 1'b0;
               err_pend_d = 1'b0;
            end
            else if (rxd != PREAMBLE_BYTE)  state_d = S_DROP;
         end
         S_HDR, S_RESOL, S_PAYLOAD, S_FCS: begin
            if (!rx_dv) begin
               state_d = S_IDLE;
            end else if (rx_er || hdr_bad || fcs_done) begin
               // Any bad byte is reported once, when rx_dv finally falls in DROP.
               state_d    = S_DROP;
               err_pend_d = hdr_accepted;
            end else begin
               crc_en = 1'b1;
               off_d  = off_q + 11'd1;
               if (state_q == S_HDR && off_q == HDR_LAST_OFF)           state_d = S_RESOL;
               else if (state_q == S_RESOL && off_q == RESOL_LAST_OFF)  state_d = S_PAYLOAD;
               else if (state_q == S_PAYLOAD && off_q == PAY_LAST_OFF)  state_d = S_FCS;
            end
         end
         S_DROP: begin
            if (!rx_dv) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pix_wr_d    = 1'b0;
      pix_data_d  = pix_data_q;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      even_d      = even_q;
      resol_hi_d  = resol_hi_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      hdr_drop_d  = 1'b0;

      if (byte_ok && state_q == S_RESOL) begin
         if (!off_q[0]) resol_hi_d = rxd[2:0];
         else           pix_y_d    = {resol_hi_q, rxd};
      end

      if (byte_ok && state_q == S_PAYLOAD) begin
         if (!off_q[0]) begin
            even_d = rxd;
         end else begin
            pix_wr_d   = 1'b1;
            pix_data_d = {even_q, rxd};
            pix_x_d    = 10'((off_q - PAY_OFF) >> 1);
         end
      end

      if (in_frame && !rx_dv) begin
         if (fcs_done) begin
            if (crc == CRC_RESIDUE && !ovf_now) frame_ok_d  = 1'b1;
            else                                frame_err_d = 1'b1;
         end
         else if (hdr_accepted) frame_err_d = 1'b1;
         else                   hdr_drop_d  = 1'b1;
      end

      if (byte_ok && hdr_bad)                          hdr_drop_d  = 1'b1;
      if (state_q == S_DROP && !rx_dv && err_pend_q)   frame_err_d = 1'b1;
   end

   assign pix_wr    = pix_wr_q;
   assign pix_data  = pix_data_q;
   assign pix_x     = pix_x_q;
   assign pix_y     = pix_y_q;
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign hdr_drop  = hdr_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_gmii_rx.sv
// tb_gmii_rx: frame-level vector table driving gmii_rx, pixel scoreboard and status counters.
`timescale 1ns/1ps
`default_nettype none

module tb_gmii_rx;

   localparam logic [10:0] PAY_LEN   = 11'd1280;
   localparam int          PAY_BYTES = 1280;
   localparam int          PAY_OFF   = 44;
   localparam int          FCS_OFF   = PAY_OFF + PAY_BYTES;
   localparam int          NC        = 13;

   logic        rx_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        rx_dv = 1'b0;
   logic        rx_er = 1'b0;
   logic [7:0]  rxd = 8'h00;
   logic        fifo_full = 1'b0;
   logic        pix_wr;
   logic [15:0] pix_data;
   logic [9:0]  pix_x;
   logic [10:0] pix_y;
   logic        frame_ok, frame_err, hdr_drop;

   always #4 rx_clk = ~rx_clk;

   gmii_rx #(
      .MY_MAC   (48'h002345678902),
      .UDP_PORT (16'h3039),
      .PAY_LEN  (PAY_LEN)
   ) dut (
      .rx_clk    (rx_clk),
      .sys_rst   (sys_rst),
      .rx_dv     (rx_dv),
      .rx_er     (rx_er),
      .rxd       (rxd),
      .fifo_full (fifo_full),
      .pix_wr    (pix_wr),
      .pix_data  (pix_data),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .hdr_drop  (hdr_drop)
   );

   typedef struct {
      logic [15:0] data;
      logic [9:0]  x;
      logic [10:0] y;
   } pix_t;

   typedef struct {
      logic [15:0] line;
      logic [7:0]  mac5;
      logic [7:0]  proto;
      int          flip_fcs;
      int          cut_at;
      int          rst_at;
      int          er_at;
      int          full_pair;
      int          extra;
      int          exp_wr;
      int          exp_ok;
      int          exp_err;
      int          exp_hdr;
      logic [2:0]  end_pulse;   // {frame_ok, frame_err, hdr_drop} the cycle after rx_dv falls
   } case_t;

   pix_t        exp_q[$];
   pix_t        mon_e;
   case_t       cases[NC];
   string       case_name[NC];
   logic [7:0]  fb[0:1400];
   int          flen;
   int          errors = 0;
   int          checks = 0;
   int          n_wr, n_ok, n_err, n_hdr;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Output monitor: pops expected pixels and counts status pulses.
   always @(posedge rx_clk) begin
      #1;
      if (pix_wr) begin
         n_wr++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pix_wr: got data=0x%04h x=%0d y=%0d, expected no write",
                     pix_data, pix_x, pix_y);
         end else begin
            mon_e = exp_q.pop_front();
            if (pix_data !== mon_e.data || pix_x !== mon_e.x || pix_y !== mon_e.y) begin
               errors++;
               $display("FAIL pixel: got data=0x%04h x=%0d y=%0d, expected data=0x%04h x=%0d y=%0d",
                        pix_data, pix_x, pix_y, mon_e.data, mon_e.x, mon_e.y);
            end
         end
      end
      if (frame_ok || frame_err || hdr_drop) begin
         checks++;
         if ($countones({frame_ok, frame_err, hdr_drop}) > 1) begin
            errors++;
            $display("FAIL status_exclusive: got ok=%0b err=%0b drop=%0b, expected one-hot",
                     frame_ok, frame_err, hdr_drop);
         end
      end
      n_ok  += int'(frame_ok);
      n_err += int'(frame_err);
      n_hdr += int'(hdr_drop);
   end

   function automatic case_t mk(input logic [15:0] line, input logic [7:0] mac5, input logic [7:0] proto,
                                input int flip, input int cut, input int rst, input int er,
                                input int full, input int extra, input int ewr, input int eok,
                                input int eerr, input int ehdr, input logic [2:0] endp);
      case_t c;
      c.line = line;  c.mac5 = mac5;  c.proto = proto;  c.flip_fcs = flip;
      c.cut_at = cut; c.rst_at = rst; c.er_at = er;     c.full_pair = full;
      c.extra = extra; c.exp_wr = ewr; c.exp_ok = eok;  c.exp_err = eerr;
      c.exp_hdr = ehdr; c.end_pulse = endp;
      return c;
   endfunction

   task automatic build(input case_t c);
      logic [31:0] crc;
      logic [31:0] fcs;
      logic [47:0] mac;
      logic        fbit;
      mac = 48'h002345678902;
      for (int i = 0; i < PAY_OFF; i++) fb[i] = 8'(i * 5 + 3);
      for (int i = 0; i < 6; i++) fb[i] = mac[47 - 8 * i -: 8];
      fb[5]  = c.mac5;
      fb[12] = 8'h08;  fb[13] = 8'h00;  fb[14] = 8'h45;
      fb[23] = c.proto;
      fb[36] = 8'h30;  fb[37] = 8'h39;
      fb[42] = c.line[15:8];
      fb[43] = c.line[7:0];
      for (int k = 0; k < PAY_BYTES; k++) fb[PAY_OFF + k] = 8'(k);
      // Reflected reference CRC-32; FCS goes out complemented, LSB byte first.
      crc = 32'hFFFF_FFFF;
      for (int i = 0; i < FCS_OFF; i++) begin
         for (int b = 0; b < 8; b++) begin
            fbit = crc[0] ^ fb[i][b];
            crc  = crc >> 1;
            if (fbit) crc = crc ^ 32'hEDB8_8320;
         end
      end
      fcs = ~crc;
      for (int j = 0; j < 4; j++) fb[FCS_OFF + j] = fcs[8 * j +: 8];
      if (c.flip_fcs != 0) fb[FCS_OFF] = fb[FCS_OFF] ^ 8'h08;
      fb[FCS_OFF + 4] = 8'hA5;
      flen = FCS_OFF + 4 + c.extra;
   endtask

   task automatic run_case(input int idx);
      case_t c;
      int    limit;
      pix_t  e;
      c = cases[idx];
      build(c);
      limit = flen;
      if (c.cut_at >= 0 && c.cut_at < limit) limit = c.cut_at;
      if (c.rst_at >= 0 && c.rst_at < limit) limit = c.rst_at;
      if (c.er_at  >= 0 && c.er_at  < limit) limit = c.er_at;
      n_wr = 0; n_ok = 0; n_err = 0; n_hdr = 0;

      for (int p = 0; p < 8; p++) begin
         @(negedge rx_clk);
         rx_dv = 1'b1;
         rxd   = (p == 7) ? 8'hD5 : 8'h55;
      end

      for (int i = 0; i < flen; i++) begin
         if (i == c.cut_at) break;
         @(negedge rx_clk);
         if (c.rst_at >= 0 && i == c.rst_at + 1) begin
            chk({case_name[idx], "_rst_pix_wr"}, 32'(pix_wr), 32'd0);
            chk({case_name[idx], "_rst_pix_data"}, 32'(pix_data), 32'd0);
            chk({case_name[idx], "_rst_pix_x"}, 32'(pix_x), 32'd0);
            chk({case_name[idx], "_rst_pix_y"}, 32'(pix_y), 32'd0);
            chk({case_name[idx], "_rst_status"}, 32'({frame_ok, frame_err, hdr_drop}), 32'd0);
         end
         sys_rst   = (i == c.rst_at);
         rx_er     = (i == c.er_at);
         fifo_full = (c.full_pair >= 0) && (i >= PAY_OFF + 2 * c.full_pair + 1)
                                        && (i <= PAY_OFF + 2 * c.full_pair + 3);
         rxd       = fb[i];
         if (c.exp_wr > 0 && i >= PAY_OFF && i < FCS_OFF && ((i - PAY_OFF) % 2) == 1 && i < limit) begin
            e.data = {fb[i - 1], fb[i]};
            e.x    = 10'((i - PAY_OFF) / 2);
            e.y    = c.line[10:0];
            exp_q.push_back(e);
         end
      end

      @(negedge rx_clk);
      rx_dv = 1'b0; rx_er = 1'b0; sys_rst = 1'b0; fifo_full = 1'b0; rxd = 8'h00;
      @(posedge rx_clk);
      #2;
      chk({case_name[idx], "_end_pulse"}, 32'({frame_ok, frame_err, hdr_drop}), 32'(c.end_pulse));
      chk({case_name[idx], "_n_pix_wr"}, 32'(n_wr), 32'(c.exp_wr));
      chk({case_name[idx], "_n_frame_ok"}, 32'(n_ok), 32'(c.exp_ok));
      chk({case_name[idx], "_n_frame_err"}, 32'(n_err), 32'(c.exp_err));
      chk({case_name[idx], "_n_hdr_drop"}, 32'(n_hdr), 32'(c.exp_hdr));
      chk({case_name[idx], "_pending_pixels"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //                    line      mac5   proto flip cut  rst  er   full ext  wr  ok err hdr end
      cases[0]  = mk(16'd5,     8'h02, 8'h11, 0, -1,  -1,  -1,  -1,  0, 640, 1, 0, 0, 3'b100);
      cases[1]  = mk(16'd5,     8'h02, 8'h11, 1, -1,  -1,  -1,  -1,  0, 640, 0, 1, 0, 3'b010);
      cases[2]  = mk(16'd5,     8'hA7, 8'h11, 0, -1,  -1,  -1,  -1,  0,   0, 0, 0, 1, 3'b000);
      cases[3]  = mk(16'd6,     8'h02, 8'h11, 0, 500, -1,  -1,  -1,  0, 228, 0, 1, 0, 3'b010);
      cases[4]  = mk(16'd7,     8'h02, 8'h11, 0, -1,  -1,  -1,  -1,  0, 640, 1, 0, 0, 3'b100);
      cases[5]  = mk(16'd8,     8'h02, 8'h11, 0, -1,  -1,  -1,  100, 0, 640, 0, 1, 0, 3'b010);
      cases[6]  = mk(16'd9,     8'h02, 8'h11, 0, -1,  300, -1,  -1,  0, 128, 0, 0, 0, 3'b000);
      cases[7]  = mk(16'd10,    8'h02, 8'h11, 0, -1,  -1,  -1,  -1,  0, 640, 1, 0, 0, 3'b100);
      cases[8]  = mk(16'd5,     8'h02, 8'h06, 0, -1,  -1,  -1,  -1,  0,   0, 0, 0, 1, 3'b000);
      cases[9]  = mk(16'd5,     8'h02, 8'h11, 0, 20,  -1,  -1,  -1,  0,   0, 0, 0, 1, 3'b001);
      cases[10] = mk(16'd11,    8'h02, 8'h11, 0, -1,  -1,  600, -1,  0, 278, 0, 1, 0, 3'b010);
      cases[11] = mk(16'd12,    8'h02, 8'h11, 0, -1,  -1,  -1,  -1,  1, 640, 0, 1, 0, 3'b010);
      cases[12] = mk(16'hF7FF,  8'h02, 8'h11, 0, -1,  -1,  -1,  -1,  0, 640, 1, 0, 0, 3'b100);
      case_name[0]  = "good_line5";      case_name[1]  = "fcs_flip";
      case_name[2]  = "mac_a7";          case_name[3]  = "dv_drop_500";
      case_name[4]  = "good_after_drop"; case_name[5]  = "fifo_full_p100";
      case_name[6]  = "rst_at_300";      case_name[7]  = "good_after_rst";
      case_name[8]  = "bad_proto";       case_name[9]  = "dv_drop_hdr20";
      case_name[10] = "rx_er_600";       case_name[11] = "extra_fcs_byte";
      case_name[12] = "good_line_max";

      repeat (3) @(negedge rx_clk);
      chk("reset_pix_wr", 32'(pix_wr), 32'd0);
      chk("reset_pix_data", 32'(pix_data), 32'd0);
      chk("reset_pix_x", 32'(pix_x), 32'd0);
      chk("reset_pix_y", 32'(pix_y), 32'd0);
      chk("reset_status", 32'({frame_ok, frame_err, hdr_drop}), 32'd0);
      sys_rst = 1'b0;
      @(negedge rx_clk);

      for (int n = 0; n < NC; n++) run_case(n);

      repeat (4) @(negedge rx_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
